gate_preactivation_mac: RTL and testbench
=========================================

// Module: gate_preactivation_mac
// PURPOSE
//  Serial multiply-accumulate stage that computes one LSTM gate pre-activation:
//  bias + sum(weight[i]*data[i]) over a NELEM-element vector.
//  Output is rounded and saturated back to BITWIDTH fixed point and drives the
//  operand input of the sigmoid/tanh activation stage directly downstream.
//  Values are signed two's complement: BITWIDTH total bits, FRACWIDTH fractional bits.
// PARAMETERS
//  BITWIDTH   18  operand/result width (signed, Q5.12 with the defaults)
//  FRACWIDTH  12  fractional bits of operands, bias and result
//  NELEM      32  elements per dot product (>=1)
//  ACCWIDTH   48  accumulator width; must be >= 2*BITWIDTH + clog2(NELEM+1) + 1
// PORTS
//  clock        in   1         rising-edge clock
//  reset        in   1         asynchronous, active-high reset
//  start        in   1         begin new dot product (honoured only when ready=1)
//  bias         in   BITWIDTH  bias term, sampled on the start edge
//  weight       in   BITWIDTH  weight element, sampled when dataValid=1 in ACCUM
//  data         in   BITWIDTH  input-vector element, sampled with weight
//  dataValid    in   1         weight/data pair valid this cycle
//  ready        out  1         1 in IDLE: start accepted
//  result       out  BITWIDTH  saturated pre-activation, to activation stage operand
//  resultValid  out  1         single-cycle pulse: result updated
//  overflow     out  1         result was saturated; updated with resultValid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, count=0, acc=0, product pipe cleared,
//   result=0, resultValid=0, overflow=0, ready=1. Reset mid-vector discards all
//   partial work; no resultValid is produced for the aborted vector.
//  FSM IDLE -> ACCUM -> DRAIN -> OUTPUT -> IDLE.
//  IDLE: ready=1. On start: acc <= sign_ext(bias) << FRACWIDTH, count <= 0,
//   go ACCUM. dataValid ignored in IDLE.
//  ACCUM: ready=0; start ignored. Each edge with dataValid=1: product register
//   <= weight*data (full 2*BITWIDTH signed), count++. dataValid=0 stalls, no
//   count change. Edge accepting element count==NELEM-1 moves to DRAIN.
//  Accumulate: acc <= acc + sign_ext(product) on the edge after each product
//   load (one-cycle product pipe). No wrap: ACCWIDTH sized to never overflow.
//  DRAIN (1 cycle): last product enters acc; go OUTPUT.
//  OUTPUT (1 cycle): r = (acc + 2^(FRACWIDTH-1)) >>> FRACWIDTH (round half up,
//   toward +inf on ties). If r > 2^(BITWIDTH-1)-1: result=max, overflow=1;
//   if r < -2^(BITWIDTH-1): result=min, overflow=1; else result=r, overflow=0.
//   resultValid=1 for exactly this cycle; return to IDLE.
//  Latency: resultValid high in the cycle after the 2nd rising edge following
//   the edge that sampled the last element (3 edges inclusive).
//  result/overflow hold their value until the next OUTPUT cycle.
//  start asserted in the same cycle resultValid is high is accepted on the next
//   edge only if state is IDLE (i.e. never in OUTPUT); back-to-back min gap = 1 cycle.
// TESTING (NELEM=4 unless noted; 1.0 = 18'h01000)
//  1 bias=0, 4x weight=1.0, data=0.5 (18'h00800) -> result 18'h02000, ovf=0,
//    resultValid exactly one cycle, 3 edges after last element.
//  2 weight=31.0 (18'h1F000), data=31.0 x4 -> result 18'h1FFFF, ovf=1;
//    data=-31.0 (18'h21000) -> result 18'h20000, ovf=1.
//  3 bias=0, elem0 weight=18'h00001, data=0.5, rest 0 -> result 18'h00001;
//    weight=18'h3FFFF (-1 LSB) -> result 18'h00000 (tie rounds up).
//  4 same as test 1 with dataValid randomly low 0-5 cycles between elements ->
//    identical result; latency from last accepted element unchanged.
//  5 reset pulse after 2 of 4 elements -> no resultValid, result=0, ready=1;
//    following full vector from test 1 -> 18'h02000 (no residue).
//  6 bias=-1.0 (18'h3F000), data all 0, extra start pulses during ACCUM ->
//    single result 18'h3F000, ovf=0, starts ignored; count unaffected.

Source files
------------

// File: rtl/gate_preactivation_mac_if.sv
// Handshake/bus bundle between the gate MAC and its neighbours: upstream operand feed and
// the downstream activation-stage operand.
// Ports: start/bias/weight/data/dataValid toward the MAC; ready/result/resultValid/overflow back.
// master modport = producer/consumer side, slave modport = the MAC itself.
interface gate_preactivation_mac_if #(
   parameter int BITWIDTH = 18
);
   logic                start;
   logic [BITWIDTH-1:0] bias;
   logic [BITWIDTH-1:0] weight;
   logic [BITWIDTH-1:0] data;
   logic                dataValid;
   logic                ready;
   logic [BITWIDTH-1:0] result;
   logic                resultValid;
   logic                overflow;

   modport master (
      output start, bias, weight, data, dataValid,
      input  ready, result, resultValid, overflow
   );

   modport slave (
      input  start, bias, weight, data, dataValid,
      output ready, result, resultValid, overflow
   );
endinterface

// File: rtl/gate_preactivation_mac.sv
// Purpose: serial MAC producing one LSTM gate pre-activation, bias + sum(w*d), rounded/saturated.
// Latency: resultValid pulses 3 edges after the edge that samples the last weight/data pair.
// Backpressure: none downstream; upstream stalls by holding dataValid low, start only taken while ready.
// Ports: clock, reset (async, active-high), bus (slave modport: start, bias, weight, data,
//        dataValid in; ready, result, resultValid, overflow out).
module gate_preactivation_mac #(
   parameter int BITWIDTH  = 18,
   parameter int FRACWIDTH = 12,
   parameter int NELEM     = 32,
   parameter int ACCWIDTH  = 48
) (
   input logic                     clock,
   input logic                     reset,
   gate_preactivation_mac_if.slave bus
);
   localparam int PW = 2 * BITWIDTH;
   localparam int CW = (NELEM > 1) ? $clog2(NELEM) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic [CW-1:0]              count;
   logic signed [ACCWIDTH-1:0] acc;
   logic signed [PW-1:0]       prod;
   logic                       prod_vld;
   logic [BITWIDTH-1:0]        result_q;
   logic                       result_vld_q;
   logic                       ovf_q;

   logic ready_c;
   logic load_bias;
   logic accept;
   logic last_elem;
   logic emit;

   logic signed [ACCWIDTH-1:0] bias_ext;
   logic signed [ACCWIDTH-1:0] prod_ext;
   logic signed [ACCWIDTH-1:0] half_lsb;
   logic signed [ACCWIDTH-1:0] acc_half;
   logic signed [ACCWIDTH-1:0] rounded;
   logic signed [ACCWIDTH-1:0] rnd_max;
   logic signed [ACCWIDTH-1:0] rnd_min;
   logic [BITWIDTH-1:0]        sat_res;
   logic                       sat_ovf;

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ACCUM;
         ACCUM:   if (last_elem) state_nxt = DRAIN;
         DRAIN:   state_nxt = OUTPUT;
         OUTPUT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs / datapath enables
   always_comb begin
      ready_c   = (state == IDLE);
      load_bias = ready_c && bus.start;
      accept    = (state == ACCUM) && bus.dataValid;
      last_elem = accept && (count == CW'(NELEM - 1));
      emit      = (state == OUTPUT);
   end

   // Round half toward +inf, then clamp to the signed BITWIDTH range.
   always_comb begin
      bias_ext = ACCWIDTH'($signed(bus.bias)) <<< FRACWIDTH;
      prod_ext = ACCWIDTH'(prod);
      half_lsb = ACCWIDTH'(1) <<< (FRACWIDTH - 1);
      acc_half = acc + half_lsb;
      rounded  = acc_half >>> FRACWIDTH;
      rnd_max  = ACCWIDTH'($signed({1'b0, {(BITWIDTH-1){1'b1}}}));
      rnd_min  = ACCWIDTH'($signed({1'b1, {(BITWIDTH-1){1'b0}}}));
      sat_res  = rounded[BITWIDTH-1:0];
      sat_ovf  = 1'b0;
      if (rounded > rnd_max) begin
         sat_res = {1'b0, {(BITWIDTH-1){1'b1}}};
         sat_ovf = 1'b1;
      end else if (rounded < rnd_min) begin
         sat_res = {1'b1, {(BITWIDTH-1){1'b0}}};
         sat_ovf = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count        <= '0;
         acc          <= '0;
         prod         <= '0;
         prod_vld     <= 1'b0;
         result_q     <= '0;
         result_vld_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         // one-cycle product pipe: product lands in acc on the following edge
         prod_vld     <= accept;
         result_vld_q <= emit;
         if (accept) begin
            prod  <= PW'($signed(bus.weight)) * PW'($signed(bus.data));
            count <= count + CW'(1);
         end
         // prod_vld is always clear in IDLE, so a bias load never drops a product
         if (load_bias) begin
            acc   <= bias_ext;
            count <= '0;
         end else if (prod_vld) begin
            acc <= acc + prod_ext;
         end
         if (emit) begin
            result_q <= sat_res;
            ovf_q    <= sat_ovf;
         end
      end
   end

   assign bus.ready       = ready_c;
   assign bus.result      = result_q;
   assign bus.resultValid = result_vld_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_gate_preactivation_mac.sv
// Bench for gate_preactivation_mac with NELEM=4, Q5.12 operands.
// Vectors from a table (plus a few modelled random ones) feed a scoreboard queue;
// hand-written sequences cover stalls, mid-vector reset and ignored start pulses.
module tb_gate_preactivation_mac;
   localparam int BW = 18;
   localparam int NE = 4;

   typedef struct packed {
      logic [BW-1:0]          bias;
      logic [NE-1:0][BW-1:0]  w;
      logic [NE-1:0][BW-1:0]  d;
      logic [BW-1:0]          res;
      logic                   ovf;
   } vec_t;

   typedef struct packed {
      logic [BW-1:0] res;
      logic          ovf;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   gate_preactivation_mac_if #(.BITWIDTH(BW)) bus();

   gate_preactivation_mac #(
      .BITWIDTH (BW),
      .FRACWIDTH(12),
      .NELEM    (NE),
      .ACCWIDTH (48)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mkv(input logic [BW-1:0] b, input logic [NE*BW-1:0] w,
                                input logic [NE*BW-1:0] d, input logic [BW-1:0] r, input logic o);
      vec_t v;
      v.bias = b;
      v.w    = w;
      v.d    = d;
      v.res  = r;
      v.ovf  = o;
      return v;
   endfunction

   // Independent reference: exact integer dot product, round half up, clamp.
   function automatic void model(inout vec_t v);
      longint s;
      s = longint'($signed(v.bias)) * 4096;
      for (int i = 0; i < NE; i++)
         s = s + longint'($signed(v.w[i])) * longint'($signed(v.d[i]));
      s = (s + 2048) >>> 12;
      if (s > 131071) begin
         v.res = 18'h1FFFF; v.ovf = 1'b1;
      end else if (s < -131072) begin
         v.res = 18'h20000; v.ovf = 1'b1;
      end else begin
         v.res = s[BW-1:0]; v.ovf = 1'b0;
      end
   endfunction

   // scoreboard: every resultValid pulse must match the oldest pending expectation
   always @(negedge clock) begin
      if (!reset && bus.resultValid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(bus.resultValid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", 32'(bus.result), 32'(mon_e.res));
            chk("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
         end
      end
   end

   // Entered and left just after a negedge.
   task automatic run_vec(input vec_t v, input bit gaps, input bit extra_start, input string tag);
      int   wait_n;
      exp_t e;
      wait_n = 0;
      while (!bus.ready && wait_n < 20) begin
         @(negedge clock);
         wait_n++;
      end
      chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
      e.res = v.res;
      e.ovf = v.ovf;
      exp_q.push_back(e);
      bus.start = 1'b1;
      bus.bias  = v.bias;
      @(negedge clock);
      bus.start = 1'b0;
      // a different bias exposes any spurious restart
      bus.bias  = extra_start ? 18'h01000 : v.bias;
      for (int i = 0; i < NE; i++) begin
         if (gaps) begin
            int g;
            g = int'($urandom_range(0, 5));
            repeat (g) begin
               bus.start = extra_start;
               @(negedge clock);
            end
         end
         bus.start     = extra_start;
         bus.dataValid = 1'b1;
         bus.weight    = v.w[i];
         bus.data      = v.d[i];
         @(negedge clock);
         bus.start     = 1'b0;
         bus.dataValid = 1'b0;
         bus.weight    = 18'h3FFFF;
         bus.data      = 18'h3FFFF;
      end
      chk({tag, "_rv_e0"}, 32'(bus.resultValid), 32'd0);
      @(negedge clock);
      chk({tag, "_rv_e1"}, 32'(bus.resultValid), 32'd0);
      @(negedge clock);
      chk({tag, "_rv_e2"}, 32'(bus.resultValid), 32'd1);
      @(negedge clock);
      chk({tag, "_rv_e3"}, 32'(bus.resultValid), 32'd0);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t rv;
      logic [31:0] r;

      bus.start     = 1'b0;
      bus.bias      = '0;
      bus.weight    = '0;
      bus.data      = '0;
      bus.dataValid = 1'b0;

      tbl[0] = mkv(18'h00000, {4{18'h01000}}, {4{18'h00800}}, 18'h02000, 1'b0);
      tbl[1] = mkv(18'h00000, {4{18'h1F000}}, {4{18'h1F000}}, 18'h1FFFF, 1'b1);
      tbl[2] = mkv(18'h00000, {4{18'h1F000}}, {4{18'h21000}}, 18'h20000, 1'b1);
      tbl[3] = mkv(18'h00000, {54'h0, 18'h00001}, {54'h0, 18'h00800}, 18'h00001, 1'b0);
      tbl[4] = mkv(18'h00000, {54'h0, 18'h3FFFF}, {54'h0, 18'h00800}, 18'h00000, 1'b0);
      tbl[5] = mkv(18'h3F000, 72'h0, 72'h0, 18'h3F000, 1'b0);
      tbl[6] = mkv(18'h00000, {54'h0, 18'h01000}, {54'h0, 18'h3FFFF}, 18'h3FFFF, 1'b0);
      tbl[7] = mkv(18'h1FFFF, 72'h0, 72'h0, 18'h1FFFF, 1'b0);
      tbl[8] = mkv(18'h20000, 72'h0, 72'h0, 18'h20000, 1'b0);
      tbl[9] = mkv(18'h1FFFF, {54'h0, 18'h00001}, {54'h0, 18'h00800}, 18'h1FFFF, 1'b1);

      repeat (2) @(negedge clock);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_rv", 32'(bus.resultValid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 10; i++)
         run_vec(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

      for (int k = 0; k < 4; k++) begin
         rv.bias = 18'($urandom());
         for (int i = 0; i < NE; i++) begin
            r       = $urandom();
            rv.w[i] = {{6{r[11]}}, r[11:0]};
            rv.d[i] = r[31:14];
         end
         model(rv);
         run_vec(rv, k[0], 1'b0, $sformatf("rnd%0d", k));
      end

      run_vec(tbl[0], 1'b1, 1'b0, "gaps");

      // abort a vector halfway with reset
      bus.start = 1'b1;
      bus.bias  = tbl[0].bias;
      @(negedge clock);
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.dataValid = 1'b1;
         bus.weight    = tbl[0].w[i];
         bus.data      = tbl[0].d[i];
         @(negedge clock);
         bus.dataValid = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_ready", 32'(bus.ready), 32'd1);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_ovf", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 6; i++) begin
         chk("abort_no_rv", 32'(bus.resultValid), 32'd0);
         @(negedge clock);
      end
      run_vec(tbl[0], 1'b0, 1'b0, "post_reset");

      run_vec(tbl[5], 1'b1, 1'b1, "extra_start");

      repeat (6) @(negedge clock);
      chk("pending_results", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
